stream_burst_iface_ctrl: RTL and testbench

- Successor to the single-word interface controller in the stream cipher path.
- Runs the chip-pin handshake for a burst of 1..2^BURST_W-1 keystream/cipher words per request, instead of one word per request.
- Adds per-word start pulses to the cipher core, a burst word counter, an abort input, and an optional processing timeout with an ERROR state.
- Sits between the chip input pins, the cipher core and the output holder block.

---
 rtl/stream_burst_iface_ctrl.sv | 159 +++++++++++++++
 tb/tb_stream_burst_iface_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_burst_iface_ctrl.sv
// Burst handshake controller between chip pins, cipher core and output holder.
// Define STREAM_IFACE_TIMEOUT_EN to enable the per-word PROCESSING timeout and ERROR state.
module stream_burst_iface_ctrl #(
    parameter int unsigned BURST_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               input_request,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               output_is_ready,
    input  logic               output_acknowledge,
    input  logic               abort,
    output logic [1:0]         interface_state,
    output logic               word_start,
    output logic               out_valid,
    output logic [BURST_W-1:0] words_done,
    output logic               busy,
    output logic               timeout_flag
);

    // The timeout counter must be able to represent TIMEOUT_CYCLES.
    if ((TIMEOUT_CYCLES >> TMO_W) != 0) begin : g_bad_tmo_w
        $error("TMO_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StProc  = 2'd1,
        StDone  = 2'd2,
        StError = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic [BURST_W-1:0] words_done_q, words_done_d;
    logic               word_start_q, word_start_d;
    logic               out_valid_q, busy_q;

`ifdef STREAM_IFACE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic             tmo_expire;
    logic             timeout_flag_q, timeout_flag_d;

    assign tmo_inc    = tmo_q + TMO_W'(1);
    assign tmo_expire = (tmo_inc == TMO_W'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        word_start_d = 1'b0;
`ifdef STREAM_IFACE_TIMEOUT_EN
        tmo_d          = '0;
        timeout_flag_d = timeout_flag_q;
`endif
        if (abort) begin
            state_d     = StIdle;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (input_request) begin
                        state_d      = StProc;
                        remaining_d  = (burst_len == '0) ? BURST_W'(1) : burst_len;
                        words_done_d = '0;
                        word_start_d = 1'b1;
`ifdef STREAM_IFACE_TIMEOUT_EN
                        timeout_flag_d = 1'b0;
`endif
                    end
                end
                StProc: begin
                    // Ready beats an expiring timeout in the same cycle.
                    if (output_is_ready) begin
                        state_d = StDone;
                    end
`ifdef STREAM_IFACE_TIMEOUT_EN
                    else if (tmo_expire) begin
                        state_d        = StError;
                        timeout_flag_d = 1'b1;
                    end else begin
                        tmo_d = tmo_inc;
                    end
`endif
                end
                StDone: begin
                    if (output_acknowledge) begin
                        if (words_done_q != '1) begin
                            words_done_d = words_done_q + BURST_W'(1);
                        end
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - BURST_W'(1);
                        end
                        if (remaining_q <= BURST_W'(1)) begin
                            state_d = StIdle;
                        end else begin
                            state_d      = StProc;
                            word_start_d = 1'b1;
                        end
                    end
                end
                StError: begin
`ifdef STREAM_IFACE_TIMEOUT_EN
                    if (output_acknowledge) begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            words_done_q <= '0;
            word_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            word_start_q <= word_start_d;
            out_valid_q  <= (state_d == StDone);
            busy_q       <= (state_d != StIdle);
        end
    end

`ifdef STREAM_IFACE_TIMEOUT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_q          <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            tmo_q          <= tmo_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign interface_state = state_q;
    assign word_start      = word_start_q;
    assign out_valid       = out_valid_q;
    assign words_done      = words_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_stream_burst_iface_ctrl.sv
// Self-checking bench for stream_burst_iface_ctrl: vector table, hand sequences, random vs model.
// Timeout checks are active when STREAM_IFACE_TIMEOUT_EN is defined.
module tb_stream_burst_iface_ctrl;

    localparam int BW      = 4;
    localparam int TMO     = 8;
    localparam int MAXDONE = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          input_request;
    logic [BW-1:0] burst_len;
    logic          output_is_ready;
    logic          output_acknowledge;
    logic          abort;
    logic [1:0]    interface_state;
    logic          word_start;
    logic          out_valid;
    logic [BW-1:0] words_done;
    logic          busy;
    logic          timeout_flag;

    int checks = 0;
    int errors = 0;

    stream_burst_iface_ctrl #(
        .BURST_W        (BW),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (4)
    ) dut (
        .clk                (clk),
        .nrst               (nrst),
        .input_request      (input_request),
        .burst_len          (burst_len),
        .output_is_ready    (output_is_ready),
        .output_acknowledge (output_acknowledge),
        .abort              (abort),
        .interface_state    (interface_state),
        .word_start         (word_start),
        .out_valid          (out_valid),
        .words_done         (words_done),
        .busy               (busy),
        .timeout_flag       (timeout_flag)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 processing, 2 done, 3 error.
    int m_mode, m_left, m_done, m_cycles;
    bit m_ws, m_flag;

    function automatic void model_reset();
        m_mode = 0; m_left = 0; m_done = 0; m_cycles = 0; m_ws = 0; m_flag = 0;
    endfunction

    function automatic void model_step(input bit rq, input int ln, input bit rd, input bit ak,
                                       input bit ab);
        m_ws = 0;
        if (ab) begin
            m_mode = 0;
            m_left = 0;
        end else if (m_mode == 0) begin
            if (rq) begin
                m_mode = 1; m_left = (ln == 0) ? 1 : ln; m_done = 0; m_ws = 1; m_flag = 0;
                m_cycles = 0;
            end
        end else if (m_mode == 1) begin
            m_cycles++;
            if (rd) m_mode = 2;
`ifdef STREAM_IFACE_TIMEOUT_EN
            else if (m_cycles >= TMO) begin
                m_mode = 3; m_flag = 1;
            end
`endif
        end else if (m_mode == 2) begin
            if (ak) begin
                m_done = (m_done < MAXDONE) ? m_done + 1 : MAXDONE;
                m_left--;
                if (m_left <= 0) m_mode = 0;
                else begin
                    m_mode = 1; m_ws = 1; m_cycles = 0;
                end
            end
        end else begin
            if (ak) m_mode = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"}, 32'(interface_state), m_mode);
        check({tag, ".word_start"}, 32'(word_start), 32'(m_ws));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_mode == 2));
        check({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
        check({tag, ".words_done"}, 32'(words_done), m_done);
        check({tag, ".timeout_flag"}, 32'(timeout_flag), 32'(m_flag));
    endtask

    task automatic drive(input bit rq, input int ln, input bit rd, input bit ak, input bit ab);
        input_request      = rq;
        burst_len          = BW'(ln);
        output_is_ready    = rd;
        output_acknowledge = ak;
        abort              = ab;
        @(posedge clk);
        model_step(rq, ln, rd, ak, ab);
        #1;
    endtask

    task automatic step(input bit rq, input int ln, input bit rd, input bit ak, input bit ab,
                        input string tag);
        drive(rq, ln, rd, ak, ab);
        check_model(tag);
    endtask

    typedef struct {
        bit    rq;
        int    ln;
        bit    rd;
        bit    ak;
        bit    ab;
        int    e_state;
        bit    e_ws;
        int    e_done;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rq, input int ln, input bit rd, input bit ak, input bit ab,
                       input int es, input bit ews, input int ed, input string name);
        vec_t v;
        v.rq = rq; v.ln = ln; v.rd = rd; v.ak = ak; v.ab = ab;
        v.e_state = es; v.e_ws = ews; v.e_done = ed; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Single word with burst_len 0.
        add(1, 0, 0, 0, 0, 1, 1, 0, "single.accept");
        add(0, 0, 0, 0, 0, 1, 0, 0, "single.proc2");
        add(0, 0, 0, 0, 0, 1, 0, 0, "single.proc3");
        add(0, 0, 1, 0, 0, 2, 0, 0, "single.ready");
        add(0, 0, 0, 1, 0, 0, 0, 1, "single.ack");
        add(0, 0, 0, 0, 0, 0, 0, 1, "single.idle");
        // Burst of 3; ack ignored in PROCESSING, ready ignored in DONE.
        add(1, 3, 0, 0, 0, 1, 1, 0, "b3.accept");
        add(0, 3, 0, 1, 0, 1, 0, 0, "b3.ack_in_proc");
        add(0, 3, 1, 0, 0, 2, 0, 0, "b3.ready1");
        add(0, 3, 1, 0, 0, 2, 0, 0, "b3.ready_in_done");
        add(0, 3, 0, 1, 0, 1, 1, 1, "b3.ack1");
        add(0, 3, 0, 0, 0, 1, 0, 1, "b3.proc2");
        add(0, 3, 1, 0, 0, 2, 0, 1, "b3.ready2");
        add(0, 3, 0, 0, 0, 2, 0, 1, "b3.wait2");
        add(0, 3, 0, 1, 0, 1, 1, 2, "b3.ack2");
        add(0, 3, 0, 0, 0, 1, 0, 2, "b3.proc3");
        add(0, 3, 1, 0, 0, 2, 0, 2, "b3.ready3");
        add(0, 3, 0, 1, 0, 0, 0, 3, "b3.ack3");
        add(0, 3, 0, 0, 0, 0, 0, 3, "b3.idle");
        // Abort in DONE after two acks of a 5-word burst, then restart.
        add(1, 5, 0, 0, 0, 1, 1, 0, "ab.accept");
        add(0, 5, 1, 0, 0, 2, 0, 0, "ab.ready1");
        add(0, 5, 0, 1, 0, 1, 1, 1, "ab.ack1");
        add(0, 5, 1, 0, 0, 2, 0, 1, "ab.ready2");
        add(0, 5, 0, 1, 0, 1, 1, 2, "ab.ack2");
        add(0, 5, 1, 0, 0, 2, 0, 2, "ab.ready3");
        add(0, 5, 0, 0, 1, 0, 0, 2, "ab.abort");
        add(1, 1, 0, 0, 1, 0, 0, 2, "ab.req_with_abort");
        add(1, 1, 0, 0, 0, 1, 1, 0, "ab.restart");
        add(0, 1, 1, 0, 0, 2, 0, 0, "ab.ready");
        add(0, 1, 0, 1, 0, 0, 0, 1, "ab.ack_last");

        model_reset();
        nrst = 1'b0;
        input_request = 0; burst_len = '0; output_is_ready = 0;
        output_acknowledge = 0; abort = 0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, "idle");

        foreach (vecs[i]) begin
            drive(vecs[i].rq, vecs[i].ln, vecs[i].rd, vecs[i].ak, vecs[i].ab);
            check({vecs[i].name, ".state"}, 32'(interface_state), vecs[i].e_state);
            check({vecs[i].name, ".word_start"}, 32'(word_start), 32'(vecs[i].e_ws));
            check({vecs[i].name, ".out_valid"}, 32'(out_valid), 32'(vecs[i].e_state == 2));
            check({vecs[i].name, ".busy"}, 32'(busy), 32'(vecs[i].e_state != 0));
            check({vecs[i].name, ".words_done"}, 32'(words_done), vecs[i].e_done);
        end

        // Back-to-back bursts with input_request held high.
        step(1, 2, 0, 0, 0, "b2b.accept");
        step(1, 2, 1, 0, 0, "b2b.ready1");
        step(1, 2, 0, 1, 0, "b2b.ack1");
        step(1, 2, 1, 0, 0, "b2b.ready2");
        step(1, 2, 0, 1, 0, "b2b.ack2");
        check("b2b.gap_idle", 32'(interface_state), 0);
        step(1, 2, 0, 0, 0, "b2b.second");
        check("b2b.second_state", 32'(interface_state), 1);
        check("b2b.second_ws", 32'(word_start), 1);
        check("b2b.second_done", 32'(words_done), 0);

        // Asynchronous reset mid-burst.
        step(0, 2, 1, 0, 0, "rst.ready");
        #2 nrst = 1'b0;
        #1;
        model_reset();
        check_model("rst.async");
        @(posedge clk);
        #1 nrst = 1'b1;
        step(0, 0, 0, 0, 0, "rst.after");

        // Full-length burst reaches the top words_done value.
        step(1, MAXDONE, 0, 0, 0, "max.accept");
        for (int i = 0; i < MAXDONE; i++) begin
            step(0, 0, 1, 0, 0, "max.ready");
            step(0, 0, 0, 1, 0, "max.ack");
        end
        check("max.words_done", 32'(words_done), MAXDONE);

`ifdef STREAM_IFACE_TIMEOUT_EN
        step(1, 1, 0, 0, 0, "tmo.accept");
        for (int i = 0; i < TMO - 1; i++) step(0, 1, 0, 0, 0, "tmo.wait");
        check("tmo.before", 32'(interface_state), 1);
        step(0, 1, 0, 0, 0, "tmo.expire");
        check("tmo.error", 32'(interface_state), 3);
        check("tmo.flag", 32'(timeout_flag), 1);
        step(1, 1, 1, 0, 0, "tmo.req_ignored");
        check("tmo.still_error", 32'(interface_state), 3);
        step(0, 1, 0, 1, 0, "tmo.ack_exit");
        check("tmo.idle", 32'(interface_state), 0);
        check("tmo.sticky", 32'(timeout_flag), 1);
        step(1, 1, 0, 0, 0, "tmo2.accept");
        check("tmo2.flag_cleared", 32'(timeout_flag), 0);
        for (int i = 0; i < TMO - 1; i++) step(0, 1, 0, 0, 0, "tmo2.wait");
        step(0, 1, 1, 0, 0, "tmo2.ready_wins");
        check("tmo2.done", 32'(interface_state), 2);
        check("tmo2.flag", 32'(timeout_flag), 0);
        step(0, 1, 0, 1, 0, "tmo2.ack");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, MAXDONE),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
